// File: rtl/ber_link_ctrl.sv
// ber_link_ctrl: oversampling strobe generator with BER checker delay alignment and lock statistics
// Ports:
//   clock, i_reset        system clock, asynchronous active-low reset
//   i_sw[3:0]             [0] tx enable, [1] rx enable, [3:2] sampling phase
//   i_bit_valid/i_bit_err checker result strobe and qualified bit mismatch
//   o_sample_en           oversample-rate enable, one cycle every CLK_DIV clocks
//   o_tx_sym_en           transmit symbol strobe (combinational)
//   o_rx_sample_en        receive downsample strobe at the active phase (combinational)
//   o_phase               sampling phase, updated only at symbol boundaries
//   o_delay_sel           checker delay index under evaluation
//   o_locked              alignment achieved
//   o_bit_cnt/o_err_cnt   saturating bit and error counts gathered while locked
//   o_led                 {err_seen, locked, rx_en, tx_en}
// Build option: define LINK_CTRL_SW_SYNC_EN to pass i_sw through a two-flop synchronizer
// ahead of its register (3-cycle latency instead of 1).
module ber_link_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int OS      = 4,
    parameter int NDLY    = 512,
    parameter int WIN     = 1024,
    parameter int THR     = 0,
    parameter int CNT_W   = 64
) (
    input  logic                                      clock,
    input  logic                                      i_reset,
    input  logic [3:0]                                i_sw,
    input  logic                                      i_bit_valid,
    input  logic                                      i_bit_err,
    output logic                                      o_sample_en,
    output logic                                      o_tx_sym_en,
    output logic                                      o_rx_sample_en,
    output logic [1:0]                                o_phase,
    output logic [(NDLY > 1 ? $clog2(NDLY) : 1)-1:0]  o_delay_sel,
    output logic                                      o_locked,
    output logic [CNT_W-1:0]                          o_bit_cnt,
    output logic [CNT_W-1:0]                          o_err_cnt,
    output logic [3:0]                                o_led
);
    localparam int DW = NDLY > 1 ? $clog2(NDLY) : 1;
    localparam int VW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int SW = OS > 4 ? $clog2(OS) : 2;
    localparam int WW = $clog2(WIN + 1);
    localparam logic [VW-1:0] DIV_LAST = VW'(CLK_DIV - 1);
    localparam logic [SW-1:0] S_LAST   = SW'(OS - 1);
    localparam logic [WW-1:0] W_LAST   = WW'(WIN - 1);
    localparam logic [DW-1:0] D_LAST   = DW'(NDLY - 1);
    localparam logic [3:0]    FLUSH    = 4'd8;

    typedef enum logic [1:0] {IDLE, SEARCH, LOCK} state_t;

    state_t        state;
    logic [3:0]    sw_q;
    logic [VW-1:0] div;
    logic [SW-1:0] scnt;
    logic [WW-1:0] win_cnt;
    logic [WW-1:0] win_err;
    logic [WW-1:0] err_tot;
    logic [3:0]    flush;
    logic [DW-1:0] dly_next;
    logic          err_seen;
    logic          tx_en;
    logic          rx_en;
    logic          win_done;

    assign tx_en          = sw_q[0];
    assign rx_en          = sw_q[1];
    assign o_tx_sym_en    = o_sample_en && scnt == '0 && tx_en;
    assign o_rx_sample_en = o_sample_en && scnt == SW'(o_phase) && rx_en;
    assign o_led          = {err_seen, o_locked, rx_en, tx_en};
    // error total including the current strobe, so a window-completing error is counted
    assign err_tot        = win_err + WW'(i_bit_valid & i_bit_err);
    assign win_done       = i_bit_valid && win_cnt == W_LAST;
    assign dly_next       = o_delay_sel == D_LAST ? '0 : o_delay_sel + 1'b1;

`ifdef LINK_CTRL_SW_SYNC_EN
    logic [3:0] sw_s1;
    logic [3:0] sw_s2;

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
            sw_q  <= '0;
        end else begin
            sw_s1 <= i_sw;
            sw_s2 <= sw_s1;
            sw_q  <= sw_s2;
        end
    end
`else
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset)
            sw_q <= '0;
        else
            sw_q <= i_sw;
    end
`endif

    // Phase is only taken at the last sample of a symbol so each symbol sees exactly one rx strobe.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            div         <= '0;
            o_sample_en <= 1'b0;
            scnt        <= '0;
            o_phase     <= '0;
        end else begin
            div         <= div == DIV_LAST ? '0 : div + 1'b1;
            o_sample_en <= div == DIV_LAST;
            if (o_sample_en) begin
                scnt <= scnt == S_LAST ? '0 : scnt + 1'b1;
                if (scnt == S_LAST)
                    o_phase <= sw_q[3:2];
            end
        end
    end

    // Alignment FSM; flush discards checker pipeline results after every delay change.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state       <= IDLE;
            o_delay_sel <= '0;
            win_cnt     <= '0;
            win_err     <= '0;
            flush       <= '0;
            o_locked    <= 1'b0;
            o_bit_cnt   <= '0;
            o_err_cnt   <= '0;
            err_seen    <= 1'b0;
        end else if (!rx_en) begin
            state       <= IDLE;
            o_delay_sel <= '0;
            win_cnt     <= '0;
            win_err     <= '0;
            flush       <= '0;
            o_locked    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state     <= SEARCH;
                    flush     <= FLUSH;
                    o_bit_cnt <= '0;
                    o_err_cnt <= '0;
                    err_seen  <= 1'b0;
                end
                SEARCH: begin
                    if (i_bit_valid) begin
                        if (flush != '0) begin
                            flush <= flush - 1'b1;
                        end else if (win_done) begin
                            win_cnt <= '0;
                            win_err <= '0;
                            if (err_tot == '0) begin
                                state    <= LOCK;
                                o_locked <= 1'b1;
                            end else begin
                                o_delay_sel <= dly_next;
                                flush       <= FLUSH;
                            end
                        end else begin
                            win_cnt <= win_cnt + 1'b1;
                            win_err <= err_tot;
                        end
                    end
                end
                LOCK: begin
                    if (i_bit_valid) begin
                        if (!(&o_bit_cnt))
                            o_bit_cnt <= o_bit_cnt + 1'b1;
                        if (i_bit_err) begin
                            err_seen <= 1'b1;
                            if (!(&o_err_cnt))
                                o_err_cnt <= o_err_cnt + 1'b1;
                        end
                        if (win_done) begin
                            win_cnt <= '0;
                            win_err <= '0;
                            if (int'(err_tot) > THR) begin
                                state       <= SEARCH;
                                o_locked    <= 1'b0;
                                o_delay_sel <= dly_next;
                                flush       <= FLUSH;
                            end
                        end else begin
                            win_cnt <= win_cnt + 1'b1;
                            win_err <= err_tot;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ber_link_ctrl.sv
// tb_ber_link_ctrl: self-checking scoreboard bench for ber_link_ctrl
module tb_ber_link_ctrl;
`ifdef LINK_CTRL_SW_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clock = 1'b0;
    logic        i_reset;
    logic [3:0]  i_sw, i_sw4;
    logic        i_bit_valid, i_bit_err, i_bit_valid4, i_bit_err4;
    logic        o_sample_en, o_tx_sym_en, o_rx_sample_en, o_locked;
    logic        o_sample_en4, o_tx_sym_en4, o_rx_sample_en4, o_locked4;
    logic [1:0]  o_phase, o_phase4, o_delay_sel4;
    logic [2:0]  o_delay_sel;
    logic [63:0] o_bit_cnt, o_err_cnt, o_bit_cnt4, o_err_cnt4;
    logic [3:0]  o_led, o_led4;
    int          cyc;
    int          n_chk = 0;
    int          n_err = 0;
    int          n;
    logic [63:0] bit_m, err_m;
    logic [63:0] qb[$], qe[$];
    int          qr[$];
    logic [1:0]  qd[$];
    logic [1:0]  prev;
    logic        ever;

    ber_link_ctrl #(.NDLY(8), .WIN(32)) u_dut (
        .clock(clock), .i_reset(i_reset), .i_sw(i_sw),
        .i_bit_valid(i_bit_valid), .i_bit_err(i_bit_err),
        .o_sample_en(o_sample_en), .o_tx_sym_en(o_tx_sym_en), .o_rx_sample_en(o_rx_sample_en),
        .o_phase(o_phase), .o_delay_sel(o_delay_sel), .o_locked(o_locked),
        .o_bit_cnt(o_bit_cnt), .o_err_cnt(o_err_cnt), .o_led(o_led)
    );

    ber_link_ctrl #(.NDLY(4), .WIN(16)) u_dut4 (
        .clock(clock), .i_reset(i_reset), .i_sw(i_sw4),
        .i_bit_valid(i_bit_valid4), .i_bit_err(i_bit_err4),
        .o_sample_en(o_sample_en4), .o_tx_sym_en(o_tx_sym_en4), .o_rx_sample_en(o_rx_sample_en4),
        .o_phase(o_phase4), .o_delay_sel(o_delay_sel4), .o_locked(o_locked4),
        .o_bit_cnt(o_bit_cnt4), .o_err_cnt(o_err_cnt4), .o_led(o_led4)
    );

    always #5 clock = ~clock;

    always @(posedge clock or negedge i_reset)
        if (!i_reset) cyc <= 0;
        else cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic lock_run(input logic err_when_not5);
        n = 0;
        for (int t = 0; t < 2000 && !o_locked; t++) begin
            i_bit_valid = 1'b1;
            i_bit_err   = err_when_not5 && o_delay_sel != 3'd5;
            n++;
            @(negedge clock);
        end
        i_bit_valid = 1'b0;
        i_bit_err   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        i_reset = 1'b0; i_sw = 4'b0001; i_sw4 = 4'b0000;
        i_bit_valid = 1'b0; i_bit_err = 1'b0; i_bit_valid4 = 1'b0; i_bit_err4 = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_sample", o_sample_en, 0);
        check("rst_strobes", {o_tx_sym_en, o_rx_sample_en}, 0);
        check("rst_phase", o_phase, 0);
        check("rst_delay", o_delay_sel, 0);
        check("rst_locked", o_locked, 0);
        check("rst_bits", o_bit_cnt, 0);
        check("rst_errs", o_err_cnt, 0);
        check("rst_led", o_led, 0);
        check("rst4_all", {o_sample_en4, o_tx_sym_en4, o_rx_sample_en4, o_locked4, o_phase4, o_delay_sel4, o_led4}, 0);
        check("rst4_cnt", o_bit_cnt4 | o_err_cnt4, 0);
        i_reset = 1'b1;
        // default timing with tx only
        for (int k = 1; k <= 64; k++) begin
            @(negedge clock);
            check("sample_en", o_sample_en, cyc % 4 == 0);
            check("tx_sym_en", o_tx_sym_en, cyc % 16 == 4);
            check("rx_idle", o_rx_sample_en, 0);
        end
        // rx on at phase 0, then phase 2 requested mid-symbol
        i_sw = 4'b0011;
        qr.push_back(68); qr.push_back(84);
        while (cyc < 144) begin
            @(negedge clock);
            if (o_rx_sample_en) check("rx_at", cyc, qr.size() > 0 ? qr.pop_front() : -1);
            if (cyc == 90) begin
                i_sw = 4'b1011;
                qr.push_back(108); qr.push_back(124); qr.push_back(140);
            end
        end
        check("rx_missing", qr.size(), 0);
        check("phase_new", o_phase, 2);
        // search through erroring delays 0..4, lock on 5
        lock_run(1'b1);
        check("lock_strobes", n, 240);
        check("lock_delay", o_delay_sel, 5);
        check("lock_bits0", o_bit_cnt, 0);
        check("lock_led", o_led, 4'b0111);
        bit_m = 0; err_m = 0;
        for (int i = 1; i <= 32; i++) begin
            i_bit_valid = 1'b1;
            i_bit_err   = i == 10;
            bit_m++;
            if (i == 10) err_m++;
            qb.push_back(bit_m); qe.push_back(err_m);
            @(negedge clock);
            check("bit_cnt", o_bit_cnt, qb.pop_front());
            check("err_cnt", o_err_cnt, qe.pop_front());
            check("err_seen", o_led[3], i >= 10);
            check("locked_win", o_locked, i < 32);
        end
        i_bit_valid = 1'b0; i_bit_err = 1'b0;
        check("relock_delay", o_delay_sel, 6);
        check("unlock_led", o_led, 4'b1011);
        // re-lock on delay 6, gather a few bits, then reset mid-lock
        lock_run(1'b0);
        check("lock6_strobes", n, 40);
        check("lock6_delay", o_delay_sel, 6);
        for (int i = 0; i < 5; i++) begin
            i_bit_valid = 1'b1;
            @(negedge clock);
        end
        i_bit_valid = 1'b0;
        check("bits_held", o_bit_cnt, 37);
        i_reset = 1'b0;
        #1;
        check("arst_flags", {o_sample_en, o_tx_sym_en, o_rx_sample_en, o_locked}, 0);
        check("arst_phase", o_phase, 0);
        check("arst_delay", o_delay_sel, 0);
        check("arst_cnt", o_bit_cnt | o_err_cnt, 0);
        check("arst_led", o_led, 0);
        repeat (2) @(negedge clock);
        i_reset = 1'b1;
        i_bit_valid = 1'b1; i_bit_err = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            i_bit_valid = 1'b0; i_bit_err = 1'b0;
            check("sw_latency", o_led[1], k >= LAT);
        end
        lock_run(1'b0);
        check("post_rst_strobes", n, 40);
        check("post_rst_delay", o_delay_sel, 0);
        check("post_rst_cnt", o_bit_cnt | o_err_cnt, 0);
        check("post_rst_led", o_led, 4'b0111);
        // NDLY=4 instance with a checker that always errors
        i_sw4 = 4'b0010; i_bit_valid4 = 1'b1; i_bit_err4 = 1'b1;
        check("dly4_start", o_delay_sel4, 0);
        qd.push_back(2'd1); qd.push_back(2'd2); qd.push_back(2'd3); qd.push_back(2'd0);
        prev = 2'd0; ever = 1'b0;
        for (int t = 0; t < 300 && qd.size() > 0; t++) begin
            @(negedge clock);
            ever = ever | o_locked4;
            if (o_delay_sel4 != prev) begin
                check("dly4", o_delay_sel4, qd.pop_front());
                prev = o_delay_sel4;
            end
        end
        check("dly4_done", qd.size(), 0);
        check("dly4_locked", ever, 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/ber_link_ctrl.md
BER_LINK_CTRL -- requirements
Module: ber_link_ctrl

Interface
REQ-001 The block SHALL have parameters CLK_DIV (default 4, clocks per sample enable), OS (default 4, samples per symbol), NDLY (default 512, alignment delay positions), WIN (default 1024, symbols per evaluation window), THR (default 0, maximum errors per window while locked) and CNT_W (default 64, statistics width).
REQ-002 Ports SHALL be:
- clock  in  1  system clock
- i_reset  in  1  asynchronous active-low reset
- i_sw  in  4  [0] tx enable, [1] rx enable, [3:2] sampling phase
- i_bit_valid  in  1  checker result strobe
- i_bit_err  in  1  checker bit mismatch, qualified by i_bit_valid
- o_sample_en  out  1  oversample-rate enable
- o_tx_sym_en  out  1  transmitter symbol strobe
- o_rx_sample_en  out  1  receiver downsample strobe
- o_phase  out  2  active sampling phase
- o_delay_sel  out  clog2(NDLY)  checker delay index
- o_locked  out  1  alignment achieved
- o_bit_cnt  out  CNT_W  bits evaluated while locked
- o_err_cnt  out  CNT_W  errors while locked
- o_led  out  4  {err_seen, locked, rx_en, tx_en}, MSB first

Function
REQ-003 A divider counting 0..CLK_DIV-1 SHALL assert o_sample_en for one cycle when it reaches CLK_DIV-1; the first pulse occurs on the CLK_DIV-th rising edge after reset release.
REQ-004 A sample counter scnt 0..OS-1 SHALL advance on each o_sample_en and wrap from OS-1 to 0.
REQ-005 o_tx_sym_en SHALL equal o_sample_en AND scnt==0 AND tx_en.
REQ-006 o_phase SHALL load i_sw[3:2] (after conditioning) only on o_sample_en with scnt==OS-1, so a phase change never produces two strobes or a skipped strobe within one symbol.
REQ-007 o_rx_sample_en SHALL equal o_sample_en AND scnt==o_phase AND rx_en.
REQ-008 The FSM SHALL have states IDLE, SEARCH and LOCK.
REQ-009 IDLE: entered whenever rx_en==0, from any state; clears o_delay_sel, window counters and o_locked, and holds o_bit_cnt and o_err_cnt.
REQ-010 IDLE->SEARCH: on rx_en==1; o_bit_cnt, o_err_cnt and err_seen clear on this transition.
REQ-011 SEARCH: count i_bit_valid strobes and qualified errors. After WIN strobes:
- zero errors -> LOCK
- otherwise o_delay_sel increments, wrapping NDLY-1 -> 0, and the window restarts
REQ-012 SEARCH: the first 8 strobes after each delay change SHALL be discarded (checker pipeline flush) and not counted in the window.
REQ-013 LOCK: o_locked=1. Each i_bit_valid increments o_bit_cnt; each qualified error increments o_err_cnt and sets err_seen. Both counters saturate at all-ones.
REQ-014 LOCK->SEARCH: when a WIN-strobe window holds more than THR errors; o_delay_sel increments and o_locked drops the next cycle.
REQ-015 The window-completing strobe SHALL be included in its window; an error on that strobe counts.
REQ-016 A strobe arriving in IDLE SHALL be ignored.
REQ-017 All outputs except the combinational strobes of REQ-005 and REQ-007 SHALL be registered.

Reset
REQ-018 While i_reset==0, all state SHALL clear immediately: counters 0, o_phase=0, FSM=IDLE, o_delay_sel=0, o_locked=0, all o_led bits 0, all strobes 0.
REQ-019 Reset asserted mid-window SHALL discard the partial window and the accumulated statistics.

Configuration
REQ-020 With LINK_CTRL_SW_SYNC_EN defined, i_sw SHALL pass a two-flop synchronizer and then a register, so a switch change reaches tx_en/rx_en 3 cycles later.
REQ-021 Without LINK_CTRL_SW_SYNC_EN, i_sw SHALL be registered once, with 1-cycle latency.
REQ-022 All other behaviour SHALL be identical with and without LINK_CTRL_SW_SYNC_EN.

Verification
REQ-023 Reset release, defaults, sw=0001 -> o_sample_en every 4 cycles, o_tx_sym_en every 16 cycles, o_rx_sample_en never.
REQ-024 sw=0011, then sw[3:2]=10 mid-symbol -> o_rx_sample_en stays at scnt 0 until the next symbol boundary, then at scnt 2; exactly one strobe per symbol throughout.
REQ-025 Checker errors on delays 0..4, error-free on delay 5 -> o_locked rises after 6 windows plus flush; o_delay_sel=5; o_bit_cnt counts from 0.
REQ-026 In LOCK with THR=0, inject one error -> o_err_cnt=1, o_led[3]=1; at window end, SEARCH with o_delay_sel=6.
REQ-027 NDLY=4, always-erroring checker -> o_delay_sel cycles 0,1,2,3,0 and never locks.
REQ-028 Reset pulse during LOCK, then sw[1] held -> all outputs 0 immediately; after release, re-lock from delay 0 with cleared counters; run with and without LINK_CTRL_SW_SYNC_EN, checking 3- vs 1-cycle switch latency.
